jtag_sync_tap: RTL and testbench

//  Parametrised JTAG TAP controller that runs entirely in the clk domain, for board-level slow-control access.
//  tck, tms and tdi are oversampled; tck edges are detected in clk, so no logic is clocked by tck.

---
 rtl/jtag_sync_tap.sv | 182 ++++++++++++++++++
 tb/tb_jtag_sync_tap.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_sync_tap.sv
// JTAG TAP controller running entirely in the clk domain. tck/tms/tdi are oversampled,
// and tck edges become one-clk rise/fall pulses that advance the TAP logic.
module jtag_sync_tap #(
   parameter int unsigned     IR_W    = 5,
   parameter int unsigned     DR_W    = 32,
   parameter int unsigned     NREG    = 4,
   parameter int unsigned     BASE    = 1,
   parameter logic [NREG-1:0] WR_MASK = {NREG{1'b1}},
   parameter logic [31:0]     ID_VAL  = 32'hA1C00288,
   parameter logic [DR_W-1:0] DR_RST  = '0
) (
   input  logic                 clk,
   input  logic                 hard_rst,
   input  logic                 tck,
   input  logic                 tms,
   input  logic                 tdi,
   output logic                 tdo,
   output logic [3:0]           tap_state,
   output logic [IR_W-1:0]      ir,
   input  logic [NREG*DR_W-1:0] cap_data,
   output logic [NREG-1:0]      cap_strobe,
   output logic [NREG*DR_W-1:0] upd_data,
   output logic [NREG-1:0]      upd_strobe
);

   // The shift register must hold the 32-bit IDCODE as well as a user register.
   localparam int unsigned SR_W = (DR_W > 32) ? DR_W : 32;
   localparam int unsigned KW   = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [3:0] {
      StTlr   = 4'd0,  StRti   = 4'd1,  StSelDr = 4'd2,  StCapDr = 4'd3,
      StShDr  = 4'd4,  StEx1Dr = 4'd5,  StPauDr = 4'd6,  StEx2Dr = 4'd7,
      StUpdDr = 4'd8,  StSelIr = 4'd9,  StCapIr = 4'd10, StShIr  = 4'd11,
      StEx1Ir = 4'd12, StPauIr = 4'd13, StEx2Ir = 4'd14, StUpdIr = 4'd15
   } tap_state_e;

   logic [1:0]      tck_sync, tms_sync, tdi_sync;
   logic            tck_s, tms_s, tdi_s, tck_d;
   logic            rise_q, fall_q;
   tap_state_e      st, st_n;
   logic [IR_W-1:0] ir_sr;
   logic [SR_W-1:0] sr, sr_cap, sr_shift, sr_r;
   logic            sel_id, sel_user;
   logic [KW-1:0]   sel_k;
   int unsigned     sel_w;

   assign tck_s     = tck_sync[1];
   assign tms_s     = tms_sync[1];
   assign tdi_s     = tdi_sync[1];
   assign tap_state = st;

   // Two-flop synchronisers and registered tck edge detection.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         tck_sync <= '0;
         tms_sync <= '1;
         tdi_sync <= '0;
         tck_d    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         tck_sync <= {tck_sync[0], tck};
         tms_sync <= {tms_sync[0], tms};
         tdi_sync <= {tdi_sync[0], tdi};
         tck_d    <= tck_s;
         rise_q   <= tck_s & ~tck_d;
         fall_q   <= ~tck_s & tck_d;
      end
   end

   // Standard 1149.1 state graph, evaluated with the synchronised tms.
   always_comb begin
      st_n = StTlr;
      case (st)
         StTlr:   st_n = tms_s ? StTlr   : StRti;
         StRti:   st_n = tms_s ? StSelDr : StRti;
         StSelDr: st_n = tms_s ? StSelIr : StCapDr;
         StCapDr: st_n = tms_s ? StEx1Dr : StShDr;
         StShDr:  st_n = tms_s ? StEx1Dr : StShDr;
         StEx1Dr: st_n = tms_s ? StUpdDr : StPauDr;
         StPauDr: st_n = tms_s ? StEx2Dr : StPauDr;
         StEx2Dr: st_n = tms_s ? StUpdDr : StShDr;
         StUpdDr: st_n = tms_s ? StSelDr : StRti;
         StSelIr: st_n = tms_s ? StTlr   : StCapIr;
         StCapIr: st_n = tms_s ? StEx1Ir : StShIr;
         StShIr:  st_n = tms_s ? StEx1Ir : StShIr;
         StEx1Ir: st_n = tms_s ? StUpdIr : StPauIr;
         StPauIr: st_n = tms_s ? StEx2Ir : StPauIr;
         StEx2Ir: st_n = tms_s ? StUpdIr : StShIr;
         StUpdIr: st_n = tms_s ? StSelDr : StRti;
         default: st_n = StTlr;
      endcase
   end

   // DR selection from the current instruction; 0 and all-ones take priority over user codes.
   always_comb begin
      sel_id   = (ir == '0);
      sel_user = 1'b0;
      sel_k    = '0;
      if (!sel_id && !(&ir)) begin
         for (int unsigned k = 0; k < NREG; k++) begin
            if (ir == IR_W'(BASE + k)) begin
               sel_user = 1'b1;
               sel_k    = KW'(k);
            end
         end
      end
      sel_w = sel_id ? 32 : (sel_user ? DR_W : 1);
   end

   // Capture value and variable-width LSB-first shift of the selected register.
   always_comb begin
      sr_cap = '0;
      if (sel_id) begin
         sr_cap[31:0] = ID_VAL;
      end else if (sel_user) begin
         sr_cap[DR_W-1:0] = cap_data[sel_k*DR_W +: DR_W];
      end
      sr_r     = sr >> 1;
      sr_shift = '0;
      for (int unsigned i = 0; i < SR_W; i++) begin
         if (i + 1 < sel_w) begin
            sr_shift[i] = sr_r[i];
         end else if (i + 1 == sel_w) begin
            sr_shift[i] = tdi_s;
         end
      end
   end

   // TAP core: state, IR/DR paths, tdo and strobes, all advanced by the edge pulses.
   always_ff @(posedge clk or negedge hard_rst) begin
      if (!hard_rst) begin
         st         <= StTlr;
         ir         <= '0;
         ir_sr      <= '0;
         sr         <= '0;
         tdo        <= 1'b0;
         cap_strobe <= '0;
         upd_strobe <= '0;
         upd_data   <= {NREG{DR_RST}};
      end else begin
         cap_strobe <= '0;
         upd_strobe <= '0;
         if (st == StTlr) begin
            ir <= '0;
         end
         if (rise_q) begin
            case (st)
               StCapIr: ir_sr <= IR_W'(1);
               StShIr:  ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
               StCapDr: begin
                  sr <= sr_cap;
                  if (sel_user) begin
                     cap_strobe[sel_k] <= 1'b1;
                  end
               end
               StShDr:  sr <= sr_shift;
               default: ;
            endcase
            st <= st_n;
         end
         if (fall_q) begin
            // tdo changes only on fall so it is stable across the host's next rise.
            if (st == StShDr) begin
               tdo <= sr[0];
            end else if (st == StShIr) begin
               tdo <= ir_sr[0];
            end else begin
               tdo <= 1'b0;
            end
            if (st == StUpdIr) begin
               ir <= ir_sr;
            end
            if (st == StUpdDr && sel_user && WR_MASK[sel_k]) begin
               upd_data[sel_k*DR_W +: DR_W] <= sr[DR_W-1:0];
               upd_strobe[sel_k]            <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_sync_tap.sv
// Bench for jtag_sync_tap: a tck-level behavioural TAP model, checked at every tck rise,
// strobe monitor every clk, directed scans with literal expectations and random traffic.
module tb_jtag_sync_tap;

   localparam int unsigned IR_W    = 5;
   localparam int unsigned DR_W    = 32;
   localparam int unsigned NREG    = 4;
   localparam int unsigned BASE    = 1;
   localparam logic [3:0]  WR_MASK = 4'b1011;
   localparam logic [31:0] ID_VAL  = 32'hA1C00288;
   localparam logic [31:0] DR_RST  = 32'hC0DE0000;

   logic                 clk, hard_rst, tck, tms, tdi, tdo;
   logic [3:0]           tap_state;
   logic [IR_W-1:0]      ir;
   logic [NREG*DR_W-1:0] cap_data, upd_data;
   logic [NREG-1:0]      cap_strobe, upd_strobe;

   jtag_sync_tap #(
      .IR_W(IR_W), .DR_W(DR_W), .NREG(NREG), .BASE(BASE),
      .WR_MASK(WR_MASK), .ID_VAL(ID_VAL), .DR_RST(DR_RST)
   ) dut (
      .clk(clk), .hard_rst(hard_rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
      .tap_state(tap_state), .ir(ir), .cap_data(cap_data), .cap_strobe(cap_strobe),
      .upd_data(upd_data), .upd_strobe(upd_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   int              nxt [16][2];
   int              m_state;
   logic [IR_W-1:0] m_ir, m_irsr;
   logic [31:0]     m_sr;
   logic            m_tdo;
   logic [DR_W-1:0] m_upd [NREG];
   int              exp_cap [NREG], exp_upd [NREG], seen_cap [NREG], seen_upd [NREG];
   int              n_vec, n_err;
   bit              run_chk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // -2: IDCODE, -1: bypass, k>=0: user register k
   function automatic int sel_of(input logic [IR_W-1:0] v);
      if (v == 0) return -2;
      if (int'(v) == (1 << IR_W) - 1) return -1;
      if (int'(v) >= BASE && int'(v) < BASE + NREG) return int'(v) - BASE;
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_ir    = '0;
      m_irsr  = '0;
      m_sr    = '0;
      m_tdo   = 1'b0;
      for (int k = 0; k < NREG; k++) m_upd[k] = DR_RST;
   endtask

   task automatic model_rise(input logic t_ms, input logic t_di);
      int s, w;
      s = sel_of(m_ir);
      case (m_state)
         10: m_irsr = IR_W'(1);
         11: m_irsr = {t_di, m_irsr[IR_W-1:1]};
         3: begin
            if (s == -2) m_sr = ID_VAL;
            else if (s == -1) m_sr = '0;
            else begin
               m_sr = cap_data[s*DR_W +: DR_W];
               exp_cap[s]++;
            end
         end
         4: begin
            w = (s == -2) ? 32 : ((s == -1) ? 1 : DR_W);
            m_sr = m_sr >> 1;
            m_sr[w-1] = t_di;
         end
         default: ;
      endcase
      m_state = nxt[m_state][t_ms];
      if (m_state == 0) m_ir = '0;
   endtask

   task automatic model_fall();
      int s;
      s = sel_of(m_ir);
      if (m_state == 15) m_ir = m_irsr;
      if (m_state == 8 && s >= 0 && WR_MASK[s]) begin
         m_upd[s] = m_sr;
         exp_upd[s]++;
      end
      m_tdo = (m_state == 4) ? m_sr[0] : ((m_state == 11) ? m_irsr[0] : 1'b0);
   endtask

   // One full tck period (80 ns low, 80 ns high); tdo is sampled just before the rise.
   task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
      tms = t_ms;
      tdi = t_di;
      #79;
      t_do = tdo;
      tck = 1'b1;
      #1 model_rise(t_ms, t_di);
      #79;
      tck = 1'b0;
      #1 model_fall();
   endtask

   task automatic go(input logic t_ms);
      logic b;
      tck_cycle(t_ms, 1'($urandom), b);
   endtask

   task automatic reset_tap();
      for (int i = 0; i < 5; i++) go(1'b1);
   endtask

   task automatic ir_scan(input logic [IR_W-1:0] v, output logic [IR_W-1:0] o);
      logic b;
      go(1'b1); go(1'b1); go(1'b0); go(1'b0);
      for (int i = 0; i < IR_W; i++) begin
         tck_cycle(i == IR_W - 1, v[i], b);
         o[i] = b;
      end
      go(1'b1); go(1'b0);
   endtask

   task automatic dr_shift(input int n, input logic [63:0] din, input bit last_exit,
                           output logic [63:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         tck_cycle(last_exit && (i == n - 1), din[i], b);
         dout[i] = b;
      end
   endtask

   task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
      go(1'b1); go(1'b0); go(1'b0);
      dr_shift(n, din, 1'b1, dout);
      go(1'b1); go(1'b0);
   endtask

   task automatic reset_pulse();
      hard_rst = 1'b0;
      #4;
      chk("rst_state", tap_state, 4'd0);
      chk("rst_ir", ir, '0);
      chk("rst_upd", upd_data, {NREG{DR_RST}});
      model_reset();
      #16 hard_rst = 1'b1;
   endtask

   // Compare DUT against the model at every tck rise, before the model takes the rise.
   always @(posedge tck) begin
      if (run_chk) begin
         chk("tap_state", tap_state, m_state);
         chk("ir", ir, m_ir);
         chk("tdo", tdo, m_tdo);
         for (int k = 0; k < NREG; k++) begin
            chk("upd_data", upd_data[k*DR_W +: DR_W], m_upd[k]);
            chk("cap_strobe_count", seen_cap[k], exp_cap[k]);
            chk("upd_strobe_count", seen_upd[k], exp_upd[k]);
         end
      end
   end

   // Strobe monitor, every clk.
   always @(negedge clk) begin
      if (run_chk) begin
         for (int k = 0; k < NREG; k++) begin
            seen_cap[k] += int'(cap_strobe[k]);
            seen_upd[k] += int'(upd_strobe[k]);
         end
         chk("cap_onehot", ($countones(cap_strobe) <= 1), 1'b1);
         chk("upd_onehot", ($countones(upd_strobe) <= 1), 1'b1);
      end
   end

   initial begin
      logic [IR_W-1:0] io;
      logic [63:0]     dout;
      logic [31:0]     d5;
      int              base, tot;
      logic [IR_W-1:0] pick;

      nxt = '{'{1, 0}, '{1, 2}, '{3, 9}, '{4, 5}, '{4, 5}, '{6, 8}, '{6, 7}, '{4, 8},
              '{1, 2}, '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15},
              '{1, 2}};
      n_vec = 0; n_err = 0; run_chk = 0;
      for (int k = 0; k < NREG; k++) begin
         exp_cap[k] = 0; exp_upd[k] = 0; seen_cap[k] = 0; seen_upd[k] = 0;
      end
      hard_rst = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; cap_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      chk("reset_state", tap_state, 4'd0);
      chk("reset_ir", ir, '0);
      chk("reset_tdo", tdo, 1'b0);
      chk("reset_upd", upd_data, {NREG{DR_RST}});
      chk("reset_strobes", {cap_strobe, upd_strobe}, '0);
      hard_rst = 1'b1;
      run_chk  = 1;

      // 1: IDCODE after TLR
      reset_tap();
      chk("tlr_state", tap_state, 4'd0);
      go(1'b0);
      dr_scan(32, 64'($urandom), dout);
      chk("idcode", dout[31:0], 32'hA1C00288);

      // 2: IR scan to register 1, DR scan
      ir_scan(5'b00010, io);
      chk("ir_capture", io, 5'b00001);
      cap_data[63:32] = 32'h12345678;
      base = seen_upd[1];
      dr_scan(32, 64'hDEADBEEF, dout);
      chk("reg1_tdo", dout[31:0], 32'h12345678);
      chk("reg1_upd", upd_data[63:32], 32'hDEADBEEF);
      chk("reg1_upd_pulses", seen_upd[1] - base, 1);

      // 3: read-only register 2
      ir_scan(5'b00011, io);
      base = seen_cap[2];
      tot  = seen_upd[0] + seen_upd[1] + seen_upd[2] + seen_upd[3];
      dr_scan(32, 64'h0F0F1234, dout);
      chk("reg2_cap_pulses", seen_cap[2] - base, 1);
      chk("reg2_upd_hold", upd_data[95:64], DR_RST);
      chk("reg2_no_upd", seen_upd[0] + seen_upd[1] + seen_upd[2] + seen_upd[3] - tot, 0);

      // 4: bypass via all-ones and via an unmapped code
      ir_scan(5'b11111, io);
      dr_scan(9, {55'd0, 1'b0, 8'hA5}, dout);
      chk("bypass_ones", dout[8:0], 9'h14A);
      ir_scan(5'b01000, io);
      dr_scan(9, {55'd0, 1'b0, 8'hA5}, dout);
      chk("bypass_unmapped", dout[8:0], 9'h14A);

      // 5: paused scan into register 0
      d5 = 32'h0BADF00D;
      ir_scan(5'b00001, io);
      go(1'b1); go(1'b0); go(1'b0);
      dr_shift(16, {48'd0, d5[15:0]}, 1'b1, dout);
      go(1'b0);
      for (int i = 0; i < 10; i++) go(1'b0);
      go(1'b1); go(1'b0);
      dr_shift(16, {48'd0, d5[31:16]}, 1'b1, dout);
      go(1'b1); go(1'b0);
      chk("paused_scan", upd_data[31:0], 32'h0BADF00D);

      // 6: reset in the middle of a register 1 shift
      ir_scan(5'b00010, io);
      go(1'b1); go(1'b0); go(1'b0);
      dr_shift(10, 64'($urandom), 1'b0, dout);
      tot = seen_upd[0] + seen_upd[1] + seen_upd[2] + seen_upd[3];
      reset_pulse();
      for (int i = 0; i < 4; i++) go(1'b1);
      chk("abort_no_upd", seen_upd[0] + seen_upd[1] + seen_upd[2] + seen_upd[3] - tot, 0);

      // Random traffic
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 5))
            0: reset_pulse();
            1, 2: begin
               for (int i = 0; i < 30; i++) begin
                  cap_data = {$urandom, $urandom, $urandom, $urandom};
                  go(($urandom_range(0, 3) == 0));
               end
            end
            default: begin
               reset_tap();
               go(1'b0);
               case ($urandom_range(0, 7))
                  0: pick = '0;
                  5: pick = '1;
                  6, 7: pick = IR_W'($urandom_range(0, 31));
                  default: pick = IR_W'($urandom_range(BASE, BASE + NREG - 1));
               endcase
               ir_scan(pick, io);
               for (int j = 0; j < $urandom_range(1, 2); j++) begin
                  cap_data = {$urandom, $urandom, $urandom, $urandom};
                  dr_scan(32, {$urandom, $urandom}, dout);
               end
            end
         endcase
      end

      go(1'b1);
      run_chk = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
